alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have these ports, one clock domain, with clock and reset listed first:
- Clock  in  1  rising-edge system clock.
- Resetn  in  1  asynchronous active-low reset.
- Run  in  1  start request, sampled only in IDLE.
- Func  in  4  operation code (ALU codes plus LOAD/MOV, see REQ-010).
- Rx  in  2  destination and first-operand register select.
- Ry  in  2  second-operand register select.
- Data  in  8  external load value.
- AluResult  in  8  combinational result returned by the ALU.
- AluInst  out  4  opcode driven to the ALU.
- AluA  out  8  ALU A operand (registered).
- BusWires  out  8  ALU second operand / internal bus.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle illegal-opcode pulse.
- Zflag  out  1  last ALU result was zero.
- Sflag  out  1  last ALU result bit 7.
- RdSel  in  2  debug read select.
- RdData  out  8  combinational contents of R[RdSel].

Function
REQ-002 The block SHALL contain four 8-bit registers R0..R3, an 8-bit A register and an 8-bit G register.
REQ-003 The FSM SHALL have five states: IDLE, T1, T2, T3 and TL.
REQ-004 In IDLE with Run=1 and an ALU opcode, the FSM SHALL go to T1 and latch Func, Rx and Ry into internal copies; later input changes SHALL be ignored.
REQ-005 In T1: BusWires = R[Rx], A <= BusWires at the T1 clock edge, next state T2.
REQ-006 In T2: BusWires = R[Ry], AluInst = latched Func, G <= AluResult, next state T3.
REQ-007 In T3: R[Rx] <= G, Zflag <= (G==0), Sflag <= G[7], Done=1, next state IDLE.
REQ-008 AluA SHALL equal A in all states, and AluInst SHALL hold the latched Func in all non-IDLE states.
REQ-009 The ALU opcodes SHALL be:
- MUL 0000, ADD 0010, SUB 0011, AND 0100, NAND 0101, OR 0110, NOR 0111, ROR 1010, ROL 1011, NOT 1100, SHL 1101, SHR 1110.
- All ALU opcodes use the full T1-T3 sequence, including the unary ones.
REQ-010 LOAD (0001) and MOV (1000) SHALL go IDLE->TL, where:
- R[Rx] <= Data (LOAD) or R[Ry] (MOV);
- BusWires shows the written value;
- Done=1; next state IDLE;
- flags are unchanged.
REQ-011 Opcodes 1001 and 1111 with Run=1 in IDLE SHALL pulse Err for one cycle, stay in IDLE and leave all registers unchanged.
REQ-012 Latency SHALL be fixed:
- with Run sampled at edge n, an ALU op asserts Done in cycle n+2 to n+3, and R[Rx] updates at edge n+3;
- LOAD/MOV asserts Done in cycle n to n+1, and R[Rx] updates at edge n+1.
REQ-013 Run while Busy=1 SHALL be ignored and not queued; back-to-back Run is accepted on the edge that the FSM is in IDLE again.
REQ-014 When Rx==Ry, T1 and T2 SHALL both read the pre-operation value; the write-back happens only in T3.
REQ-015 In IDLE, BusWires SHALL be 0, AluInst SHALL be 0000 and Done=Err=0.
REQ-016 Arithmetic SHALL be modulo 256: G takes AluResult[7:0], and no carry is stored.

Reset
REQ-017 Resetn=0 SHALL immediately, without waiting for a Clock edge:
- set the state to IDLE;
- clear R0..R3, A, G, the latched Func/Rx/Ry, Zflag and Sflag to 0;
- clear Done, Err and Busy to 0.
REQ-018 Reset asserted mid-operation SHALL abort the sequence with no write-back, and the block SHALL accept Run on the first edge after Resetn rises.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- LOAD R1=0x3C, then LOAD R2=0x05, then ADD Rx=1 Ry=2 -> R1=0x41, Zflag=0, Sflag=0, Done exactly 3 cycles after Run is sampled.
- LOAD R0=0x80, then SUB Rx=0 Ry=0 -> R0=0x00, Zflag=1, Sflag=0.
- With R3=0x81, issue ROL Rx=3 -> R3=0x03; then issue NOT Rx=3 -> R3=0xFC, Sflag=1.
- Run with Func=1001 -> Err pulses for 1 cycle, Busy stays 0, RdData for R0..R3 is unchanged.
- Pulse Run again during T2 of a MUL with R1=0x10, R2=0x11 -> the extra Run is ignored, R1=0x10, only one Done.
- Assert Resetn=0 in T2 of an ADD -> all registers 0 and IDLE without a clock edge; a LOAD issued after release completes normally.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle register-file sequencer driving an external ALU
module alu_seq_ctrl (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [3:0] Func,
    input  logic [1:0] Rx,
    input  logic [1:0] Ry,
    input  logic [7:0] Data,
    input  logic [7:0] AluResult,
    output logic [3:0] AluInst,
    output logic [7:0] AluA,
    output logic [7:0] BusWires,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic       Zflag,
    output logic       Sflag,
    input  logic [1:0] RdSel,
    output logic [7:0] RdData
);

    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_MOV  = 4'b1000;
    localparam logic [3:0] OP_BAD0 = 4'b1001;
    localparam logic [3:0] OP_BAD1 = 4'b1111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        TL   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] regs [4];
    logic [7:0] a_reg;
    logic [7:0] g_reg;
    logic [3:0] func_q;
    logic [1:0] rx_q;
    logic [1:0] ry_q;
    logic       err_q;
    logic       zflag_q;
    logic       sflag_q;

    logic       is_move;
    logic       is_illegal;
    logic       accept;

    assign is_move    = (Func == OP_LOAD) || (Func == OP_MOV);
    assign is_illegal = (Func == OP_BAD0) || (Func == OP_BAD1);
    // A request is only taken while idle; anything arriving mid-sequence is dropped.
    assign accept     = (state == IDLE) && Run && !is_illegal;

    assign AluA   = a_reg;
    assign Busy   = (state != IDLE);
    assign Err    = err_q;
    assign Zflag  = zflag_q;
    assign Sflag  = sflag_q;
    assign RdData = regs[RdSel];

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus bus, opcode and completion outputs
    always_comb begin
        state_next = state;
        BusWires   = 8'h00;
        AluInst    = 4'b0000;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_move ? TL : T1;
                end
            end
            T1: begin
                AluInst    = func_q;
                BusWires   = regs[rx_q];
                state_next = T2;
            end
            T2: begin
                AluInst    = func_q;
                BusWires   = regs[ry_q];
                state_next = T3;
            end
            T3: begin
                AluInst    = func_q;
                BusWires   = g_reg;
                Done       = 1'b1;
                state_next = IDLE;
            end
            TL: begin
                AluInst    = func_q;
                BusWires   = (func_q == OP_LOAD) ? Data : regs[ry_q];
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: request latch, operand/result staging, write-back and flags
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
            a_reg   <= 8'h00;
            g_reg   <= 8'h00;
            func_q  <= 4'b0000;
            rx_q    <= 2'd0;
            ry_q    <= 2'd0;
            err_q   <= 1'b0;
            zflag_q <= 1'b0;
            sflag_q <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && Run && is_illegal;
            if (accept) begin
                func_q <= Func;
                rx_q   <= Rx;
                ry_q   <= Ry;
            end
            case (state)
                T1: a_reg <= BusWires;
                T2: g_reg <= AluResult;
                T3: begin
                    regs[rx_q] <= g_reg;
                    zflag_q    <= (g_reg == 8'h00);
                    sflag_q    <= g_reg[7];
                end
                TL: regs[rx_q] <= BusWires;
                default: ;
            endcase
        end
    end

endmodule
